ifetch_v5: RTL and testbench

Instruction fetch stage for the RV32IMV_V5 core. It sits directly upstream of the 64-word instruction ROM and directly downstream-feeds the decode stage. It owns the program counter, drives the ROM word address, and captures each returned instruction word together with its PC into a small in-order queue. It presents the queue head to decode over a valid/ready handshake and supports redirect (branch/jump/`jr`), halt and backpressure.

---
 rtl/ifetch_v5.sv | 109 ++++++++++
 tb/tb_ifetch_v5.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ifetch_v5.sv
// rtl/ifetch_v5.sv - instruction fetch stage with PC, ROM address and in-order fetch queue
//
// Purpose: owns the program counter, addresses the instruction ROM, captures
// each {pc, inst} pair into a small circular queue and presents the queue
// head to decode over a valid/ready handshake. Supports redirect, halt and
// backpressure.
//
// Parameters:
//   RESET_PC    PC loaded on reset
//   QDEPTH      queue entries (2 or 4)
// Ports:
//   clk         clock, rising edge
//   clrn        asynchronous active-low reset
//   imem_a      ROM byte address (the PC register)
//   imem_inst   ROM word for imem_a, combinational
//   redirect    load redirect_pc and flush the queue
//   redirect_pc redirect target (low two bits ignored)
//   halt        suppress new fetches; queue still drains
//   id_valid    queue head valid for decode
//   id_inst     head instruction word
//   id_pc       head PC
//   id_ready    decode accepts the head this cycle
//   id_illegal  head word is the all-zero ROM padding value
//   q_count     current queue occupancy

module ifetch_v5 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      clrn,
  output logic [31:0]               imem_a,
  input  logic [31:0]               imem_inst,
  input  logic                      redirect,
  input  logic [31:0]               redirect_pc,
  input  logic                      halt,
  output logic                      id_valid,
  output logic [31:0]               id_inst,
  output logic [31:0]               id_pc,
  input  logic                      id_ready,
  output logic                      id_illegal,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(QDEPTH);

  logic [31:0]   r_pc;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_q_pc   [QDEPTH];
  logic [31:0]   r_q_inst [QDEPTH];

  logic w_valid;
  logic w_deq;
  logic w_enq;
  logic [1:0] w_unused_rpc_lo;

  assign w_unused_rpc_lo = redirect_pc[1:0];

  // Redirect masks the head so a stale entry is never consumed in the flush cycle.
  assign w_valid = (r_count != '0) & ~redirect;
  assign w_deq   = w_valid & id_ready;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign w_enq   = ~redirect & ~halt & ((r_count < C_DEPTH) | w_deq);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_pc[i]   <= '0;
        r_q_inst[i] <= '0;
      end
    end else if (redirect) begin
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_q_pc[r_tail]   <= r_pc;
        r_q_inst[r_tail] <= imem_inst;
        r_tail           <= r_tail + PW'(1);
        r_pc             <= r_pc + 32'd4;
      end
      if (w_deq) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign imem_a     = r_pc;
  assign id_valid   = w_valid;
  assign id_inst    = r_q_inst[r_head];
  assign id_pc      = r_q_pc[r_head];
  assign id_illegal = w_valid & (r_q_inst[r_head] == 32'h0);
  assign q_count    = r_count;

endmodule

// File: tb/tb_ifetch_v5.sv
// tb/tb_ifetch_v5.sv - directed table-driven bench for ifetch_v5
module tb_ifetch_v5;

  logic        clk;
  logic        clrn;
  logic [31:0] imem_a;
  logic [31:0] imem_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        id_illegal;
  logic [1:0]  q_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [64];
  assign imem_inst = rom[imem_a[7:2]];

  ifetch_v5 #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk(clk), .clrn(clrn), .imem_a(imem_a), .imem_inst(imem_inst),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_ready(id_ready), .id_illegal(id_illegal), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        hlt;
    logic        rdy;
    logic        e_v;
    logic [31:0] e_pc;
    logic [1:0]  e_cnt;
    logic [31:0] e_a;
    logic        e_ill;
  } vec_t;

  vec_t vecs [30];

  function automatic vec_t mk(logic rd, logic [31:0] rpc, logic hlt, logic rdy,
                              logic e_v, logic [31:0] e_pc, logic [1:0] e_cnt,
                              logic [31:0] e_a, logic e_ill);
    vec_t v;
    v.rd = rd; v.rpc = rpc; v.hlt = hlt; v.rdy = rdy;
    v.e_v = e_v; v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_a = e_a; v.e_ill = e_ill;
    return v;
  endfunction

  function automatic logic [31:0] rom_word(logic [31:0] pc);
    logic [5:0] idx;
    idx = pc[7:2];
    if (idx == 6'd20) return 32'h0;
    return 32'hA500_0000 | {26'h0, idx};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = rom_word(32'(i) << 2);

    //            rd  rpc           hlt rdy  v  head pc       cnt imem_a       ill
    vecs[0]  = mk(0, 32'h0,        0, 1,   0, 32'h0,        0, 32'h0,        0);
    vecs[1]  = mk(0, 32'h0,        0, 1,   1, 32'h0,        1, 32'h4,        0);
    vecs[2]  = mk(0, 32'h0,        0, 1,   1, 32'h4,        1, 32'h8,        0);
    vecs[3]  = mk(0, 32'h0,        0, 1,   1, 32'h8,        1, 32'hC,        0);
    vecs[4]  = mk(0, 32'h0,        0, 0,   1, 32'hC,        1, 32'h10,       0);
    vecs[5]  = mk(0, 32'h0,        0, 0,   1, 32'hC,        2, 32'h14,       0);
    vecs[6]  = mk(0, 32'h0,        0, 0,   1, 32'hC,        2, 32'h14,       0);
    vecs[7]  = mk(0, 32'h0,        0, 1,   1, 32'hC,        2, 32'h14,       0);
    vecs[8]  = mk(0, 32'h0,        0, 1,   1, 32'h10,       2, 32'h18,       0);
    vecs[9]  = mk(0, 32'h0,        0, 0,   1, 32'h14,       2, 32'h1C,       0);
    vecs[10] = mk(1, 32'h3C,       0, 1,   0, 32'h0,        2, 32'h1C,       0);
    vecs[11] = mk(0, 32'h0,        0, 1,   0, 32'h0,        0, 32'h3C,       0);
    vecs[12] = mk(0, 32'h0,        0, 1,   1, 32'h3C,       1, 32'h40,       0);
    vecs[13] = mk(1, 32'h41,       0, 1,   0, 32'h0,        1, 32'h44,       0);
    vecs[14] = mk(0, 32'h0,        0, 1,   0, 32'h0,        0, 32'h40,       0);
    vecs[15] = mk(0, 32'h0,        0, 1,   1, 32'h40,       1, 32'h44,       0);
    vecs[16] = mk(0, 32'h0,        1, 1,   1, 32'h44,       1, 32'h48,       0);
    vecs[17] = mk(0, 32'h0,        1, 1,   0, 32'h0,        0, 32'h48,       0);
    vecs[18] = mk(0, 32'h0,        1, 1,   0, 32'h0,        0, 32'h48,       0);
    vecs[19] = mk(0, 32'h0,        0, 1,   0, 32'h0,        0, 32'h48,       0);
    vecs[20] = mk(0, 32'h0,        0, 1,   1, 32'h48,       1, 32'h4C,       0);
    vecs[21] = mk(1, 32'hFFFFFFFC, 1, 1,   0, 32'h0,        1, 32'h50,       0);
    vecs[22] = mk(0, 32'h0,        0, 1,   0, 32'h0,        0, 32'hFFFFFFFC, 0);
    vecs[23] = mk(0, 32'h0,        0, 1,   1, 32'hFFFFFFFC, 1, 32'h0,        0);
    vecs[24] = mk(0, 32'h0,        0, 1,   1, 32'h0,        1, 32'h4,        0);
    vecs[25] = mk(1, 32'h4C,       0, 1,   0, 32'h0,        1, 32'h8,        0);
    vecs[26] = mk(0, 32'h0,        0, 1,   0, 32'h0,        0, 32'h4C,       0);
    vecs[27] = mk(0, 32'h0,        0, 1,   1, 32'h4C,       1, 32'h50,       0);
    vecs[28] = mk(0, 32'h0,        0, 1,   1, 32'h50,       1, 32'h54,       1);
    vecs[29] = mk(0, 32'h0,        0, 1,   1, 32'h54,       1, 32'h58,       0);

    clrn = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst id_valid",   {31'h0, id_valid},   32'h0);
    chk("rst id_inst",    id_inst,             32'h0);
    chk("rst id_pc",      id_pc,               32'h0);
    chk("rst id_illegal", {31'h0, id_illegal}, 32'h0);
    chk("rst q_count",    {30'h0, q_count},    32'h0);
    chk("rst imem_a",     imem_a,              32'h0);
    clrn = 1'b1;

    for (int i = 0; i < 30; i++) begin
      redirect = vecs[i].rd; redirect_pc = vecs[i].rpc;
      halt = vecs[i].hlt;    id_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("s%0d id_valid", i),   {31'h0, id_valid},   {31'h0, vecs[i].e_v});
      chk($sformatf("s%0d q_count", i),    {30'h0, q_count},    {30'h0, vecs[i].e_cnt});
      chk($sformatf("s%0d imem_a", i),     imem_a,              vecs[i].e_a);
      chk($sformatf("s%0d id_illegal", i), {31'h0, id_illegal}, {31'h0, vecs[i].e_ill});
      if (vecs[i].e_v) begin
        chk($sformatf("s%0d id_pc", i),   id_pc,   vecs[i].e_pc);
        chk($sformatf("s%0d id_inst", i), id_inst, rom_word(vecs[i].e_pc));
      end
      @(posedge clk);
      #1;
    end

    // Fill the queue, then pulse reset between clock edges.
    redirect = 1'b0; halt = 1'b0; id_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-rst q_count", {30'h0, q_count}, 32'h2);
    #2;
    clrn = 1'b0;
    #1;
    chk("async id_valid", {31'h0, id_valid}, 32'h0);
    chk("async q_count",  {30'h0, q_count},  32'h0);
    chk("async imem_a",   imem_a,            32'h0);
    chk("async id_pc",    id_pc,             32'h0);
    chk("async id_inst",  id_inst,           32'h0);
    @(negedge clk);
    clrn = 1'b1;
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("refetch%0d id_valid", k), {31'h0, id_valid}, 32'h1);
      chk($sformatf("refetch%0d id_pc", k),    id_pc,   32'(k) << 2);
      chk($sformatf("refetch%0d id_inst", k),  id_inst, rom_word(32'(k) << 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
